// File: rtl/i2c_master_burst_ctrl.sv
// i2c_master_burst_ctrl
// Byte/burst-level controller for the I2C master. It runs one command as a
// sequence of bit-level operations on the bit controller: an optional START,
// then Len+1 data words of DW bits with per-word ACK handling, then an
// optional STOP.
//
// Ports
//   Clk, Rst_n                   clock, asynchronous active-low reset
//   Start/Stop/Read/Write, Len   command bits and burst length minus one,
//                                sampled only in IDLE
//   Tx_ack                       ACK/NACK bit the master sends after the last
//                                read word
//   Tx_data/Tx_valid/Tx_ready    write-word handshake
//   Rx_data/Rx_valid             received word and its one-cycle strobe
//   Rx_ack                       ACK bit the slave returned for the last
//                                written word
//   Byte_cnt                     words completed in the current/last command
//   Bit_cmd/Bit_txd              bit-level operation and bit to transmit
//   Bit_ack/Bit_rxd              bit operation done and received bit
//   I2C_al                       arbitration lost
//   I2C_busy/I2C_done/Al_err     status: busy, done pulse, sticky arb-lost flag
module i2c_master_burst_ctrl #(
  parameter int unsigned DW    = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Read,
  input  logic             Write,
  input  logic [LEN_W-1:0] Len,
  input  logic             Tx_ack,
  input  logic [DW-1:0]    Tx_data,
  input  logic             Tx_valid,
  output logic             Tx_ready,
  output logic [DW-1:0]    Rx_data,
  output logic             Rx_valid,
  output logic             Rx_ack,
  output logic [LEN_W:0]   Byte_cnt,
  output logic [3:0]       Bit_cmd,
  output logic             Bit_txd,
  input  logic             Bit_ack,
  input  logic             Bit_rxd,
  input  logic             I2C_al,
  output logic             I2C_busy,
  output logic             I2C_done,
  output logic             Al_err
);

  // Bit-controller command codes shared with i2c_master_defines.
  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  localparam int unsigned BW = (DW > 2) ? $clog2(DW) : 1;

  typedef enum logic [2:0] {
    IDLE, START, LOAD, XFER, ACK, STOP, DONE
  } state_t;

  state_t           state;
  logic             c_stop;
  logic             c_read;
  logic             c_write;
  logic [LEN_W-1:0] len;
  logic [DW-1:0]    sr;
  logic [BW-1:0]    bit_cnt;
  logic             last_word;

  // Byte_cnt still holds the index of the word in flight until its ACK phase.
  always_comb begin
    last_word = (Byte_cnt == {1'b0, len});
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      c_stop   <= 1'b0;
      c_read   <= 1'b0;
      c_write  <= 1'b0;
      len      <= '0;
      sr       <= '0;
      bit_cnt  <= '0;
      Tx_ready <= 1'b0;
      Rx_data  <= '0;
      Rx_valid <= 1'b0;
      Rx_ack   <= 1'b0;
      Byte_cnt <= '0;
      Bit_cmd  <= CMD_NOP;
      Bit_txd  <= 1'b0;
      I2C_busy <= 1'b0;
      I2C_done <= 1'b0;
      Al_err   <= 1'b0;
    end else begin
      Tx_ready <= 1'b0;
      Rx_valid <= 1'b0;
      I2C_done <= 1'b0;

      if (state != IDLE && I2C_al) begin
        // Abandon the command on the spot: no STOP, counters frozen.
        state    <= IDLE;
        Bit_cmd  <= CMD_NOP;
        Bit_txd  <= 1'b0;
        Al_err   <= 1'b1;
        I2C_done <= 1'b1;
        I2C_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (Start || Stop || Read || Write) begin
              c_stop   <= Stop;
              c_write  <= Write;
              c_read   <= Read & ~Write;
              len      <= Len;
              Byte_cnt <= '0;
              Al_err   <= 1'b0;
              Rx_ack   <= 1'b0;
              I2C_busy <= 1'b1;
              if (Start) begin
                state   <= START;
                Bit_cmd <= CMD_START;
              end else if (Read || Write) begin
                state   <= LOAD;
              end else begin
                state   <= STOP;
                Bit_cmd <= CMD_STOP;
              end
            end
          end

          START: begin
            if (Bit_ack) begin
              Bit_cmd <= CMD_NOP;
              if (c_read || c_write) begin
                state <= LOAD;
              end else begin
                state    <= DONE;
                I2C_done <= 1'b1;
                I2C_busy <= 1'b0;
              end
            end
          end

          LOAD: begin
            bit_cnt <= BW'(DW - 1);
            if (c_write) begin
              if (Tx_valid) begin
                Tx_ready <= 1'b1;
                sr       <= Tx_data;
                Bit_cmd  <= CMD_WRITE;
                Bit_txd  <= Tx_data[DW-1];
                state    <= XFER;
              end
            end else begin
              Bit_cmd <= CMD_READ;
              Bit_txd <= 1'b0;
              state   <= XFER;
            end
          end

          XFER: begin
            if (Bit_ack) begin
              bit_cnt <= bit_cnt - 1'b1;
              if (c_write) sr <= {sr[DW-2:0], 1'b0};
              else         sr <= {sr[DW-2:0], Bit_rxd};
              if (bit_cnt == '0) begin
                state <= ACK;
                if (c_write) begin
                  Bit_cmd <= CMD_READ;
                  Bit_txd <= 1'b0;
                end else begin
                  Bit_cmd <= CMD_WRITE;
                  Bit_txd <= last_word ? Tx_ack : 1'b0;
                end
              end else if (c_write) begin
                // sr[DW-1] is the bit just sent; the next one sits below it.
                Bit_txd <= sr[DW-2];
              end
            end
          end

          ACK: begin
            if (Bit_ack) begin
              Byte_cnt <= Byte_cnt + 1'b1;
              Bit_txd  <= 1'b0;
              if (c_write) begin
                Rx_ack <= Bit_rxd;
              end else begin
                Rx_data  <= sr;
                Rx_valid <= 1'b1;
              end
              if (last_word || (c_write && Bit_rxd)) begin
                if (c_stop) begin
                  state   <= STOP;
                  Bit_cmd <= CMD_STOP;
                end else begin
                  state    <= DONE;
                  Bit_cmd  <= CMD_NOP;
                  I2C_done <= 1'b1;
                  I2C_busy <= 1'b0;
                end
              end else begin
                state   <= LOAD;
                Bit_cmd <= CMD_NOP;
              end
            end
          end

          STOP: begin
            if (Bit_ack) begin
              state    <= DONE;
              Bit_cmd  <= CMD_NOP;
              I2C_done <= 1'b1;
              I2C_busy <= 1'b0;
            end
          end

          DONE: begin
            state <= IDLE;
          end

          default: begin
            state   <= IDLE;
            Bit_cmd <= CMD_NOP;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_burst_ctrl.sv
// Testbench for i2c_master_burst_ctrl: directed and randomized commands
// checked against a transaction-level model of the expected bit operations,
// received words, word count and ACK status.
module tb_i2c_master_burst_ctrl;
  localparam int DW    = 8;
  localparam int LEN_W = 4;

  localparam logic [3:0] C_NOP   = 4'b0000;
  localparam logic [3:0] C_START = 4'b0001;
  localparam logic [3:0] C_STOP  = 4'b0010;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_READ  = 4'b1000;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic             Start, Stop, Read, Write;
  logic [LEN_W-1:0] Len;
  logic             Tx_ack;
  logic [DW-1:0]    Tx_data;
  logic             Tx_valid;
  logic             Tx_ready;
  logic [DW-1:0]    Rx_data;
  logic             Rx_valid;
  logic             Rx_ack;
  logic [LEN_W:0]   Byte_cnt;
  logic [3:0]       Bit_cmd;
  logic             Bit_txd;
  logic             Bit_ack;
  logic             Bit_rxd;
  logic             I2C_al;
  logic             I2C_busy;
  logic             I2C_done;
  logic             Al_err;

  always #5 Clk = ~Clk;

  i2c_master_burst_ctrl #(.DW(DW), .LEN_W(LEN_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Start(Start), .Stop(Stop), .Read(Read), .Write(Write), .Len(Len),
    .Tx_ack(Tx_ack), .Tx_data(Tx_data), .Tx_valid(Tx_valid), .Tx_ready(Tx_ready),
    .Rx_data(Rx_data), .Rx_valid(Rx_valid), .Rx_ack(Rx_ack), .Byte_cnt(Byte_cnt),
    .Bit_cmd(Bit_cmd), .Bit_txd(Bit_txd), .Bit_ack(Bit_ack), .Bit_rxd(Bit_rxd),
    .I2C_al(I2C_al), .I2C_busy(I2C_busy), .I2C_done(I2C_done), .Al_err(Al_err)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] cmd;
    logic       txd;
    logic       rxd;
  } op_t;

  op_t           ops[$];
  logic [DW-1:0] rx_exp[$];
  logic [DW-1:0] txw[16];
  logic [DW-1:0] rxw[16];
  logic          nack[16];
  int            exp_words;
  logic          exp_rx_ack;

  // Reference: the full list of bit operations a command must produce, with
  // the bit the slave answers for each, plus the expected end status.
  function automatic void build(input logic st, input logic sp, input logic rd,
                                input logic wr, input int len, input logic tx_ack);
    logic rde;
    rde = rd & ~wr;
    ops.delete();
    rx_exp.delete();
    exp_words  = 0;
    exp_rx_ack = 1'b0;
    if (st) ops.push_back('{C_START, 1'b0, 1'b0});
    if (wr) begin
      for (int w = 0; w <= len; w++) begin
        for (int b = DW - 1; b >= 0; b--) ops.push_back('{C_WRITE, txw[w][b], 1'b0});
        ops.push_back('{C_READ, 1'b0, nack[w]});
        exp_words++;
        exp_rx_ack = nack[w];
        if (nack[w]) break;
      end
    end else if (rde) begin
      for (int w = 0; w <= len; w++) begin
        for (int b = DW - 1; b >= 0; b--) ops.push_back('{C_READ, 1'b0, rxw[w][b]});
        ops.push_back('{C_WRITE, (w == len) ? tx_ack : 1'b0, 1'b0});
        exp_words++;
        rx_exp.push_back(rxw[w]);
      end
    end
    if (sp && (wr || rde || !st)) ops.push_back('{C_STOP, 1'b0, 1'b0});
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      txw[i]  = DW'($urandom);
      rxw[i]  = DW'($urandom);
      nack[i] = 1'b0;
    end
  endtask

  // Drives one command and plays the slave/bit controller until done.
  // al_at >= 0 raises I2C_al while bit operation number al_at is pending.
  task automatic run_cmd(input logic st, input logic sp, input logic rd, input logic wr,
                         input int len, input logic tx_ack, input int al_at,
                         input bit hold_tx, input string name);
    int  ops_done = 0;
    int  delay    = -1;
    int  tx_idx   = 0;
    int  wcnt     = 0;
    int  done_cnt = 0;
    int  cyc      = 0;
    int  gap_mark;
    bit  al_fired = 0;
    bit  finished = 0;
    build(st, sp, rd, wr, len, tx_ack);
    gap_mark = (st ? 1 : 0) + DW + 1;
    @(negedge Clk);
    Start = st; Stop = sp; Read = rd; Write = wr; Len = LEN_W'(len);
    Tx_ack = tx_ack; Tx_data = txw[0]; Tx_valid = wr;
    while (!finished) begin
      @(negedge Clk);
      cyc++;
      Start = 0; Stop = 0; Read = 0; Write = 0; I2C_al = 0; Bit_ack = 0;
      if (al_fired) begin
        tests++;
        if (Bit_cmd !== C_NOP || Al_err !== 1'b1 || I2C_done !== 1'b1 ||
            I2C_busy !== 1'b0 || Byte_cnt !== '0) begin
          fails++;
          $display("FAIL %s al_abort: got cmd=%h al_err=%b done=%b busy=%b cnt=%0d, want cmd=0 al_err=1 done=1 busy=0 cnt=0",
                   name, Bit_cmd, Al_err, I2C_done, I2C_busy, Byte_cnt);
        end
        finished = 1;
      end else begin
        if (Tx_ready) begin
          tx_idx++;
          if (tx_idx < 16) Tx_data = txw[tx_idx];
        end
        if (hold_tx && tx_idx == 1 && wcnt < 5 && ops_done == gap_mark) begin
          wcnt++;
          tests++;
          if (Bit_cmd !== C_NOP) begin
            fails++;
            $display("FAIL %s wait_nop: got cmd=%h, want cmd=0", name, Bit_cmd);
          end
        end
        Tx_valid = wr && tx_idx <= len && !(hold_tx && tx_idx == 1 && wcnt < 5);
        if (Rx_valid) begin
          tests++;
          if (rx_exp.size() == 0) begin
            fails++;
            $display("FAIL %s rx_extra: got %h, want no word", name, Rx_data);
          end else if (Rx_data !== rx_exp[0]) begin
            fails++;
            $display("FAIL %s rx_data: got %h, want %h", name, Rx_data, rx_exp[0]);
            void'(rx_exp.pop_front());
          end else begin
            void'(rx_exp.pop_front());
          end
        end
        if (I2C_done) begin
          done_cnt++;
          finished = 1;
        end
        if (Bit_cmd !== C_NOP) begin
          if (delay < 0) delay = int'($urandom_range(0, 2));
          if (al_at >= 0 && al_at == ops_done) begin
            I2C_al   = 1;
            al_fired = 1;
          end else if (delay == 0) begin
            tests++;
            if (ops_done >= ops.size()) begin
              fails++;
              $display("FAIL %s op_extra: got cmd=%h, want none", name, Bit_cmd);
              Bit_rxd = 1'b0;
            end else begin
              if (Bit_cmd !== ops[ops_done].cmd ||
                  (Bit_cmd == C_WRITE && Bit_txd !== ops[ops_done].txd)) begin
                fails++;
                $display("FAIL %s op%0d: got cmd=%h txd=%b, want cmd=%h txd=%b", name, ops_done,
                         Bit_cmd, Bit_txd, ops[ops_done].cmd, ops[ops_done].txd);
              end
              Bit_rxd = ops[ops_done].rxd;
            end
            Bit_ack = 1;
            ops_done++;
            delay = -1;
          end else begin
            delay--;
          end
        end else begin
          delay = -1;
        end
      end
      if (!finished && cyc > 3000) begin
        tests++;
        fails++;
        $display("FAIL %s timeout: got no done after %0d cycles, want done", name, cyc);
        finished = 1;
      end
    end
    Tx_valid = 0;
    if (!al_fired) begin
      tests++;
      if (done_cnt != 1 || ops_done != ops.size() || rx_exp.size() != 0) begin
        fails++;
        $display("FAIL %s sequence: got done=%0d ops=%0d rx_left=%0d, want done=1 ops=%0d rx_left=0",
                 name, done_cnt, ops_done, rx_exp.size(), ops.size());
      end
      tests++;
      if (tx_idx != (wr ? exp_words : 0)) begin
        fails++;
        $display("FAIL %s tx_ready_count: got %0d, want %0d", name, tx_idx, wr ? exp_words : 0);
      end
      tests++;
      if (Byte_cnt !== (LEN_W + 1)'(exp_words) || Rx_ack !== exp_rx_ack ||
          I2C_busy !== 1'b0 || Al_err !== 1'b0) begin
        fails++;
        $display("FAIL %s status: got cnt=%0d rx_ack=%b busy=%b al_err=%b, want cnt=%0d rx_ack=%b busy=0 al_err=0",
                 name, Byte_cnt, Rx_ack, I2C_busy, Al_err, exp_words, exp_rx_ack);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      Bit_ack = 0;
      tests++;
      if (Bit_cmd !== C_NOP || I2C_done !== 1'b0 || I2C_busy !== 1'b0 || Al_err !== al_fired) begin
        fails++;
        $display("FAIL %s idle: got cmd=%h done=%b busy=%b al_err=%b, want cmd=0 done=0 busy=0 al_err=%b",
                 name, Bit_cmd, I2C_done, I2C_busy, Al_err, al_fired);
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    tests++;
    if ({Bit_cmd, Bit_txd, Tx_ready, Rx_valid, Rx_data, Rx_ack, Byte_cnt,
         I2C_busy, I2C_done, Al_err} !== '0) begin
      fails++;
      $display("FAIL %s: got cmd=%h txd=%b tr=%b rv=%b rd=%h rack=%b cnt=%0d busy=%b done=%b al=%b, want all 0",
               name, Bit_cmd, Bit_txd, Tx_ready, Rx_valid, Rx_data, Rx_ack, Byte_cnt,
               I2C_busy, I2C_done, Al_err);
    end
  endtask

  task automatic test_reset();
    Rst_n = 0; Start = 0; Stop = 0; Read = 0; Write = 0; Len = '0; Tx_ack = 0;
    Tx_data = '0; Tx_valid = 0; Bit_ack = 0; Bit_rxd = 0; I2C_al = 0;
    repeat (3) @(negedge Clk);
    check_reset_values("reset");
    Rst_n = 1;
    @(negedge Clk);
    check_reset_values("after_reset");
  endtask

  task automatic test_write_single();
    fill_random();
    txw[0] = 8'hA5;
    run_cmd(1, 1, 0, 1, 0, 0, -1, 0, "write_single");
  endtask

  task automatic test_read_burst();
    fill_random();
    rxw[0] = 8'h3C; rxw[1] = 8'hFF; rxw[2] = 8'h01;
    run_cmd(0, 1, 1, 0, 2, 1, -1, 0, "read_burst");
  endtask

  task automatic test_write_nack();
    fill_random();
    nack[1] = 1'b1;
    run_cmd(0, 0, 0, 1, 3, 0, -1, 0, "write_nack");
  endtask

  task automatic test_tx_wait();
    fill_random();
    run_cmd(1, 1, 0, 1, 2, 0, -1, 1, "tx_wait");
  endtask

  task automatic test_arb_lost();
    fill_random();
    run_cmd(0, 1, 0, 1, 1, 0, 4, 0, "arb_lost");
    run_cmd(0, 1, 0, 0, 0, 0, -1, 0, "after_arb_lost");
  endtask

  task automatic test_start_stop_only();
    fill_random();
    run_cmd(0, 1, 0, 0, 0, 0, -1, 0, "stop_only");
    run_cmd(1, 0, 0, 0, 0, 0, -1, 0, "start_only");
  endtask

  task automatic test_max_len();
    fill_random();
    run_cmd(1, 1, 0, 1, 15, 0, -1, 0, "max_len_write");
    run_cmd(0, 0, 1, 0, 15, 0, -1, 0, "max_len_read");
  endtask

  task automatic test_random();
    logic st, sp, rd, wr;
    for (int n = 0; n < 12; n++) begin
      fill_random();
      for (int i = 0; i < 16; i++) nack[i] = ($urandom_range(0, 7) == 0);
      st = 1'($urandom); sp = 1'($urandom); rd = 1'($urandom); wr = 1'($urandom);
      if (!(st || sp || rd || wr)) sp = 1'b1;
      run_cmd(st, sp, rd, wr, int'($urandom_range(0, 5)), 1'($urandom), -1,
              bit'($urandom_range(0, 3) == 0), "random");
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    fill_random();
    @(negedge Clk);
    Write = 1; Len = 4'd0; Tx_data = 8'h5A; Tx_valid = 1;
    @(negedge Clk);
    Write = 0;
    while (Bit_cmd !== C_WRITE && cyc < 10) begin
      @(negedge Clk);
      cyc++;
    end
    tests++;
    if (Bit_cmd !== C_WRITE || I2C_busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_xfer: got cmd=%h busy=%b, want cmd=4 busy=1", Bit_cmd, I2C_busy);
    end
    Rst_n = 0;
    #1;
    check_reset_values("reset_mid");
    @(negedge Clk);
    Tx_valid = 0;
    Rst_n = 1;
    @(negedge Clk);
    check_reset_values("reset_mid_release");
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_read_burst();
    test_write_nack();
    test_tx_wait();
    test_arb_lost();
    test_start_stop_only();
    test_max_len();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
